irq_timer_controller: RTL and testbench
=======================================

# irq_timer_controller

Parametrised interrupt and timer block for the 68000 system controller. It replaces the fixed 50 Hz tick and fixed IPL encoding with NUM_TIMERS programmable down-counters, each with a CPU-visible byte register file. It merges timer and external interrupt sources into a registered IPL encoding and answers IACK cycles with either autovector (VPA_n) or a per-level external acknowledge.

## Interface
Parameters:
- NUM_TIMERS, 2: timer channels, 1..4.
- TIMER_WIDTH, 24: counter/reload width, 8..24.
- DEFAULT_RELOAD, 399999: timer 0 reset reload (20 MHz / 50 Hz − 1).
- TIMER_LEVELS, {3'd4,3'd6}: packed 3-bit IRQ level per timer; timer 0 in LSBs; values 1..7.
- AUTOVEC_MASK, 7'b1101111: bit L−1 set → level L autovectored; clear → external vector.

Ports:
- CLK_CPU  in  1  CPU clock
- RST_n  in  1  synchronous, active-low reset
- AS_n, RW, LDS_n  in  1 each  CPU bus strobes
- FC  in  3  function code
- ADDR  in  3  CPU A[3:1] (IACK level)
- CS_n  in  1  register-file select, decoded externally
- REG_ADDR  in  5  byte register offset
- DATA_IN  in  8  write data D[7:0]
- DATA_OUT  out  8  registered read data; reset 0
- DTACK_n  out  1  register access acknowledge; reset 1
- IRQ_EXT  in  7  active-high level requests, bit L−1 = level L
- IPL_n  out  3  encoded priority, active low; reset 3'b111
- VPA_n  out  1  autovector request; reset 1
- IACK_EXT_n  out  7  per-level external acknowledge; reset all 1

## Operation
- Per-timer register map: base k·8. Offsets:
  - +0 CTRL: bit0 EN, bit1 ONESHOT, bit2 IE.
  - +1 STATUS: bit0 PEND; write 1 clears it.
  - +2/+3/+4 RELOAD [23:16]/[15:8]/[7:0]; bits above TIMER_WIDTH read 0 and ignore writes.
  - +5/+6/+7 COUNT, read-only.
- Unmapped offsets read 0 and ignore writes.
- Reset values:
  - Timer 0: CTRL=3'b101, RELOAD=DEFAULT_RELOAD, COUNT=DEFAULT_RELOAD.
  - Other timers: all 0.
  - All PEND=0.
- Register access: a cycle with CS_n=0, AS_n=0, LDS_n=0 is accepted at a clock edge. At the next edge, DTACK_n goes 0, the write is performed once, and DATA_OUT is loaded. DTACK_n stays 0 until the first edge with AS_n=1. No second write occurs within one bus cycle.
- Counter while EN=1: decrements each cycle. At COUNT==0:
  - PEND is set.
  - Periodic mode: COUNT reloads to RELOAD. Period = RELOAD+1 cycles.
  - ONESHOT: EN clears and COUNT stays 0.
- EN 0→1 write loads COUNT=RELOAD. A RELOAD write while running takes effect at the next expiry. RELOAD=0 expires every cycle.
- Source at level L = IRQ_EXT[L−1] OR any (PEND & IE) timer mapped to L. IPL_n = ~(highest active level), registered, one-cycle latency.
- IACK cycle: FC=3'b111, AS_n=0, level = ADDR.
  - Autovectored level: VPA_n=0 from the next edge. The lowest-index timer pending at that level has PEND cleared on that edge.
  - Vectored level: IACK_EXT_n[level−1]=0 from the next edge.
  - Both outputs release on the first edge with AS_n=1.
  - An IACK with no pending source at an autovectored level still asserts VPA_n, for 68000 spurious/autovector handling.

## Timing
- Write-to-effect: 1 cycle. Expiry-to-IPL_n: 2 cycles (PEND register, IPL register).
- Same-edge expiry and W1C/IACK clear: set wins, PEND=1.
- Same-edge CTRL write and expiry: the write wins. EN takes the written value, and PEND is still set.
- Same-level timers acknowledged one per IACK cycle, in index order.
- Level 7 is passed through like other levels; no edge detection.
- Reset asserted mid bus cycle: all outputs return to reset values on that edge. The aborted write has no effect.
- COUNT wraps only via reload, never below 0.

## Structure
- Shared package sysctl_pkg:
  - Register offset localparams.
  - CTRL bit indices.
  - FC_IACK = 3'b111.
  - Level-to-IPL encode function.
- Sub-module tick_timer, instanced NUM_TIMERS times. It holds CTRL, RELOAD, COUNT, PEND, with write-enable/byte-select inputs and an iack_clr input.
- Top level holds the bus handshake, read mux, priority encoder and IACK logic.

## Test plan
- Reset, run 400000 cycles → first PEND on timer 0 at cycle 400000; IPL_n=3'b001 two cycles later.
- Set timer 1 RELOAD=9, CTRL=3'b111 → PEND once after 10 cycles; EN reads 0; no further expiry.
- IACK at level 6 with timer 0 pending → VPA_n=0 one cycle later, PEND cleared, VPA_n=1 one cycle after AS_n rises.
- IRQ_EXT[4]=1, IACK level 5 → IACK_EXT_n=7'b1101111, VPA_n=1; IPL_n=3'b010 while level 6 is idle.
- W1C of STATUS on the same edge as expiry → PEND reads 1.
- Write with AS_n held low 5 cycles → exactly one register update; DTACK_n low from cycle 2 until AS_n high.

Source files
------------

// File: rtl/sysctl_pkg.sv
// Shared definitions for the 68000 system controller:
// register offsets, CTRL bits, IACK function code and IPL encoding.
package sysctl_pkg;

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_STATUS  = 3'd1;
    localparam logic [2:0] OFF_RL_HI   = 3'd2;
    localparam logic [2:0] OFF_RL_MID  = 3'd3;
    localparam logic [2:0] OFF_RL_LO   = 3'd4;
    localparam logic [2:0] OFF_CNT_HI  = 3'd5;
    localparam logic [2:0] OFF_CNT_MID = 3'd6;
    localparam logic [2:0] OFF_CNT_LO  = 3'd7;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IE      = 2;

    localparam logic [2:0] FC_IACK = 3'b111;

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_ACC,
        BUS_ACK
    } bus_state_e;

    // Highest set request bit -> active-low IPL code (7 = idle).
    function automatic logic [2:0] ipl_encode(input logic [6:0] src);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (src[i]) lvl = 3'(i + 1);
        end
        return ~lvl;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// One programmable down-counter channel: CTRL, RELOAD, COUNT, PEND.
// Expiry sets PEND with priority over software or IACK clears.
module tick_timer
    import sysctl_pkg::*;
#(
    parameter int             W          = 24,
    parameter logic [2:0]     RST_CTRL   = 3'b000,
    parameter logic [W-1:0]   RST_RELOAD = '0
) (
    input  logic         CLK_CPU,
    input  logic         RST_n,
    input  logic         we,
    input  logic [2:0]   off,
    input  logic [7:0]   wdata,
    input  logic         iack_clr,
    output logic [2:0]   ctrl,
    output logic [W-1:0] reload,
    output logic [W-1:0] count,
    output logic         pend
);

    logic        en;
    logic        expire;
    logic        ctrl_we;
    logic        stat_we;
    logic [23:0] rl_ext;
    logic [23:0] rl_nxt;

    assign en      = ctrl[CTRL_EN];
    assign expire  = en && (count == '0);
    assign ctrl_we = we && (off == OFF_CTRL);
    assign stat_we = we && (off == OFF_STATUS) && wdata[0];
    assign rl_ext  = 24'(reload);

    always_comb begin
        rl_nxt = rl_ext;
        if (we) begin
            case (off)
                OFF_RL_HI:  rl_nxt[23:16] = wdata;
                OFF_RL_MID: rl_nxt[15:8]  = wdata;
                OFF_RL_LO:  rl_nxt[7:0]   = wdata;
                default:    rl_nxt        = rl_ext;
            endcase
        end
    end

    always_ff @(posedge CLK_CPU) begin
        if (!RST_n) begin
            ctrl   <= RST_CTRL;
            reload <= RST_RELOAD;
            count  <= RST_RELOAD;
            pend   <= 1'b0;
        end else begin
            reload <= rl_nxt[W-1:0];

            // A CTRL write overrides the one-shot self-disable.
            if (ctrl_we)
                ctrl <= wdata[2:0];
            else if (expire && ctrl[CTRL_ONESHOT])
                ctrl[CTRL_EN] <= 1'b0;

            if (ctrl_we && !en && wdata[CTRL_EN])
                count <= reload;
            else if (expire)
                count <= ctrl[CTRL_ONESHOT] ? '0 : reload;
            else if (en)
                count <= count - 1'b1;

            if (expire)
                pend <= 1'b1;
            else if (stat_we || iack_clr)
                pend <= 1'b0;
        end
    end

endmodule

// File: rtl/irq_timer_controller.sv
// Timer/interrupt block: bus handshake, register read mux,
// registered IPL priority encoder and IACK autovector/vector logic.
module irq_timer_controller
    import sysctl_pkg::*;
#(
    parameter int                    NUM_TIMERS     = 2,
    parameter int                    TIMER_WIDTH    = 24,
    parameter int                    DEFAULT_RELOAD = 399999,
    parameter logic [3*NUM_TIMERS-1:0] TIMER_LEVELS = {3'd4, 3'd6},
    parameter logic [6:0]            AUTOVEC_MASK   = 7'b1101111
) (
    input  logic       CLK_CPU,
    input  logic       RST_n,
    input  logic       AS_n,
    input  logic       RW,
    input  logic       LDS_n,
    input  logic [2:0] FC,
    input  logic [2:0] ADDR,
    input  logic       CS_n,
    input  logic [4:0] REG_ADDR,
    input  logic [7:0] DATA_IN,
    output logic [7:0] DATA_OUT,
    output logic       DTACK_n,
    input  logic [6:0] IRQ_EXT,
    output logic [2:0] IPL_n,
    output logic       VPA_n,
    output logic [6:0] IACK_EXT_n
);

    localparam logic [TIMER_WIDTH-1:0] DEF_RL = TIMER_WIDTH'(DEFAULT_RELOAD);

    bus_state_e bus_q, bus_d;

    logic                  iack_cyc;
    logic                  reg_req;
    logic                  do_acc;
    logic [1:0]            sel;
    logic [2:0]            off;
    logic [7:0]            rdata;
    logic [6:0]            src;
    logic                  iack_q;
    logic                  iack_start;
    logic                  iack_av;
    logic [7:0]            av_ext;
    logic [7:0]            lvl_oh;
    logic [NUM_TIMERS-1:0] clr;
    logic [NUM_TIMERS-1:0] pend;
    logic [2:0]            ctrl  [NUM_TIMERS];
    logic [23:0]           rl24  [NUM_TIMERS];
    logic [23:0]           cnt24 [NUM_TIMERS];
    logic [2:0]            lvl   [NUM_TIMERS];

    assign iack_cyc = (FC == FC_IACK) && !AS_n;
    assign reg_req  = !CS_n && !AS_n && !LDS_n && !iack_cyc;
    assign sel      = REG_ADDR[4:3];
    assign off      = REG_ADDR[2:0];
    assign DTACK_n  = (bus_q != BUS_ACK);

    always_comb begin
        bus_d  = bus_q;
        do_acc = 1'b0;
        case (bus_q)
            BUS_IDLE: if (reg_req) bus_d = BUS_ACC;
            BUS_ACC: begin
                do_acc = !AS_n;
                bus_d  = AS_n ? BUS_IDLE : BUS_ACK;
            end
            BUS_ACK:  if (AS_n) bus_d = BUS_IDLE;
            default:  bus_d = BUS_IDLE;
        endcase
    end

    for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_tmr
        logic [TIMER_WIDTH-1:0] reload;
        logic [TIMER_WIDTH-1:0] count;

        tick_timer #(
            .W          (TIMER_WIDTH),
            .RST_CTRL   ((k == 0) ? 3'b101 : 3'b000),
            .RST_RELOAD ((k == 0) ? DEF_RL : '0)
        ) u_tmr (
            .CLK_CPU  (CLK_CPU),
            .RST_n    (RST_n),
            .we       (do_acc && !RW && (sel == 2'(k))),
            .off      (off),
            .wdata    (DATA_IN),
            .iack_clr (clr[k]),
            .ctrl     (ctrl[k]),
            .reload   (reload),
            .count    (count),
            .pend     (pend[k])
        );

        assign rl24[k]  = 24'(reload);
        assign cnt24[k] = 24'(count);
        assign lvl[k]   = TIMER_LEVELS[3*k +: 3];
    end

    always_comb begin
        rdata = 8'h00;
        for (int k = 0; k < NUM_TIMERS; k++) begin
            if (sel == 2'(k)) begin
                case (off)
                    OFF_CTRL:    rdata = {5'b0, ctrl[k]};
                    OFF_STATUS:  rdata = {7'b0, pend[k]};
                    OFF_RL_HI:   rdata = rl24[k][23:16];
                    OFF_RL_MID:  rdata = rl24[k][15:8];
                    OFF_RL_LO:   rdata = rl24[k][7:0];
                    OFF_CNT_HI:  rdata = cnt24[k][23:16];
                    OFF_CNT_MID: rdata = cnt24[k][15:8];
                    default:     rdata = cnt24[k][7:0];
                endcase
            end
        end
    end

    always_comb begin
        src = IRQ_EXT;
        for (int k = 0; k < NUM_TIMERS; k++) begin
            if (pend[k] && ctrl[k][CTRL_IE] && (lvl[k] != 3'd0))
                src[lvl[k] - 3'd1] = 1'b1;
        end
    end

    assign av_ext     = {AUTOVEC_MASK, 1'b0};
    assign lvl_oh     = 8'b1 << ADDR;
    assign iack_start = iack_cyc && !iack_q && (ADDR != 3'd0);
    assign iack_av    = av_ext[ADDR];

    // Only the lowest-index pending timer at the level is acknowledged.
    always_comb begin
        clr = '0;
        for (int k = NUM_TIMERS - 1; k >= 0; k--) begin
            if (iack_start && iack_av && pend[k] &&
                ctrl[k][CTRL_IE] && (lvl[k] == ADDR)) begin
                clr    = '0;
                clr[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_CPU) begin
        if (!RST_n) begin
            bus_q      <= BUS_IDLE;
            DATA_OUT   <= 8'h00;
            IPL_n      <= 3'b111;
            iack_q     <= 1'b0;
            VPA_n      <= 1'b1;
            IACK_EXT_n <= 7'h7f;
        end else begin
            bus_q <= bus_d;
            IPL_n <= ipl_encode(src);
            if (do_acc) DATA_OUT <= rdata;
            if (AS_n) begin
                iack_q     <= 1'b0;
                VPA_n      <= 1'b1;
                IACK_EXT_n <= 7'h7f;
            end else if (iack_start) begin
                iack_q <= 1'b1;
                if (iack_av) VPA_n <= 1'b0;
                else         IACK_EXT_n <= ~lvl_oh[7:1];
            end
        end
    end

endmodule

// File: tb/tb_irq_timer_controller.sv
// Directed bench for irq_timer_controller with a short timer-0 reload
// so that the reset-default tick is reached in a few hundred cycles.
module tb_irq_timer_controller;

    logic       CLK_CPU;
    logic       RST_n;
    logic       AS_n;
    logic       RW;
    logic       LDS_n;
    logic [2:0] FC;
    logic [2:0] ADDR;
    logic       CS_n;
    logic [4:0] REG_ADDR;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT;
    logic       DTACK_n;
    logic [6:0] IRQ_EXT;
    logic [2:0] IPL_n;
    logic       VPA_n;
    logic [6:0] IACK_EXT_n;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic       wr;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    irq_timer_controller #(
        .DEFAULT_RELOAD (199)
    ) dut (
        .CLK_CPU    (CLK_CPU),
        .RST_n      (RST_n),
        .AS_n       (AS_n),
        .RW         (RW),
        .LDS_n      (LDS_n),
        .FC         (FC),
        .ADDR       (ADDR),
        .CS_n       (CS_n),
        .REG_ADDR   (REG_ADDR),
        .DATA_IN    (DATA_IN),
        .DATA_OUT   (DATA_OUT),
        .DTACK_n    (DTACK_n),
        .IRQ_EXT    (IRQ_EXT),
        .IPL_n      (IPL_n),
        .VPA_n      (VPA_n),
        .IACK_EXT_n (IACK_EXT_n)
    );

    initial CLK_CPU = 1'b0;
    always #5 CLK_CPU = ~CLK_CPU;

    task automatic tick();
        @(posedge CLK_CPU);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bus_idle();
        AS_n  = 1'b1;
        CS_n  = 1'b1;
        LDS_n = 1'b1;
        RW    = 1'b1;
        FC    = 3'b101;
    endtask

    task automatic reg_wr(input logic [4:0] a, input logic [7:0] d);
        CS_n = 1'b0; AS_n = 1'b0; LDS_n = 1'b0; RW = 1'b0;
        FC = 3'b101; REG_ADDR = a; DATA_IN = d;
        tick();
        tick();
        bus_idle();
        tick();
    endtask

    task automatic reg_rd(input logic [4:0] a, output logic [7:0] d);
        CS_n = 1'b0; AS_n = 1'b0; LDS_n = 1'b0; RW = 1'b1;
        FC = 3'b101; REG_ADDR = a;
        tick();
        tick();
        d = DATA_OUT;
        bus_idle();
        tick();
    endtask

    initial begin
        logic [7:0] d;
        n_cmp = 0;
        n_bad = 0;

        tbl[0]  = '{1'b1, 5'h0A, 8'hAB, 8'h00};
        tbl[1]  = '{1'b0, 5'h0A, 8'h00, 8'hAB};
        tbl[2]  = '{1'b1, 5'h0B, 8'h12, 8'h00};
        tbl[3]  = '{1'b0, 5'h0B, 8'h00, 8'h12};
        tbl[4]  = '{1'b0, 5'h04, 8'h00, 8'hC7};
        tbl[5]  = '{1'b0, 5'h03, 8'h00, 8'h00};
        tbl[6]  = '{1'b0, 5'h00, 8'h00, 8'h00};
        tbl[7]  = '{1'b1, 5'h0D, 8'h55, 8'h00};
        tbl[8]  = '{1'b0, 5'h0D, 8'h00, 8'h00};
        tbl[9]  = '{1'b1, 5'h12, 8'h77, 8'h00};
        tbl[10] = '{1'b0, 5'h12, 8'h00, 8'h00};
        tbl[11] = '{1'b1, 5'h08, 8'hF8, 8'h00};
        tbl[12] = '{1'b0, 5'h08, 8'h00, 8'h00};
        tbl[13] = '{1'b1, 5'h0A, 8'h00, 8'h00};
        tbl[14] = '{1'b1, 5'h0B, 8'h00, 8'h00};

        RST_n = 1'b0;
        bus_idle();
        ADDR = 3'd0; IRQ_EXT = 7'h00; REG_ADDR = 5'h00; DATA_IN = 8'h00;
        repeat (3) tick();
        chk("rst_data_out", DATA_OUT, 8'h00);
        chk("rst_dtack", DTACK_n, 1'b1);
        chk("rst_ipl", IPL_n, 3'b111);
        chk("rst_vpa", VPA_n, 1'b1);
        chk("rst_iack_ext", IACK_EXT_n, 7'h7f);

        // Timer 0 default: reload 199, first PEND at edge 200.
        RST_n = 1'b1;
        repeat (199) tick();
        chk("ipl_before_expiry", IPL_n, 3'b111);
        tick();
        chk("ipl_pend_edge", IPL_n, 3'b111);
        tick();
        chk("ipl_t0_level6", IPL_n, 3'b001);
        reg_rd(5'h01, d);
        chk("t0_pend_set", d, 8'h01);

        FC = 3'b111; ADDR = 3'd6; AS_n = 1'b0;
        tick();
        chk("iack6_vpa", VPA_n, 1'b0);
        chk("iack6_ext", IACK_EXT_n, 7'h7f);
        tick();
        tick();
        chk("iack6_vpa_hold", VPA_n, 1'b0);
        AS_n = 1'b1; FC = 3'b101;
        tick();
        chk("iack6_vpa_release", VPA_n, 1'b1);
        chk("iack6_ipl_idle", IPL_n, 3'b111);
        reg_rd(5'h01, d);
        chk("t0_pend_cleared", d, 8'h00);

        FC = 3'b111; ADDR = 3'd3; AS_n = 1'b0;
        tick();
        chk("spurious_vpa", VPA_n, 1'b0);
        AS_n = 1'b1; FC = 3'b101;
        tick();
        chk("spurious_release", VPA_n, 1'b1);

        reg_wr(5'h00, 8'h00);
        reg_wr(5'h01, 8'h01);

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].wr) begin
                reg_wr(tbl[i].addr, tbl[i].wdata);
            end else begin
                reg_rd(tbl[i].addr, d);
                chk($sformatf("tbl%0d_addr%0h", i, tbl[i].addr), d, tbl[i].exp);
            end
        end

        // One-shot timer 1, reload 9: expiry 10 edges after the CTRL write.
        reg_wr(5'h0C, 8'h09);
        reg_wr(5'h08, 8'h07);
        repeat (8) tick();
        chk("os_ipl_w9", IPL_n, 3'b111);
        tick();
        chk("os_ipl_w10", IPL_n, 3'b111);
        tick();
        chk("os_ipl_level4", IPL_n, 3'b011);
        reg_rd(5'h08, d);
        chk("os_en_cleared", d, 8'h06);
        reg_rd(5'h09, d);
        chk("os_pend", d, 8'h01);
        reg_rd(5'h0F, d);
        chk("os_count_zero", d, 8'h00);
        repeat (30) tick();
        reg_wr(5'h09, 8'h01);
        repeat (30) tick();
        reg_rd(5'h09, d);
        chk("os_no_reexpiry", d, 8'h00);

        IRQ_EXT = 7'b0010000;
        tick();
        tick();
        chk("ext5_ipl", IPL_n, 3'b010);
        FC = 3'b111; ADDR = 3'd5; AS_n = 1'b0;
        tick();
        chk("ext5_iack", IACK_EXT_n, 7'b1101111);
        chk("ext5_vpa", VPA_n, 1'b1);
        AS_n = 1'b1; FC = 3'b101;
        tick();
        chk("ext5_release", IACK_EXT_n, 7'h7f);
        IRQ_EXT = 7'h00;

        // W1C lands on the same edge as the first periodic expiry.
        reg_wr(5'h08, 8'h05);
        repeat (7) tick();
        reg_wr(5'h09, 8'h01);
        reg_rd(5'h09, d);
        chk("w1c_vs_expiry", d, 8'h01);
        reg_wr(5'h08, 8'h00);
        reg_wr(5'h09, 8'h01);

        // Reload 0 one-shot: a repeated write would re-enable the timer.
        reg_wr(5'h0C, 8'h00);
        CS_n = 1'b0; AS_n = 1'b0; LDS_n = 1'b0; RW = 1'b0;
        REG_ADDR = 5'h08; DATA_IN = 8'h03;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("held_dtack_c%0d", i), DTACK_n, (i == 1) ? 1'b1 : 1'b0);
        end
        bus_idle();
        tick();
        chk("held_dtack_release", DTACK_n, 1'b1);
        reg_rd(5'h08, d);
        chk("held_single_write", d, 8'h02);
        reg_rd(5'h09, d);
        chk("held_pend", d, 8'h01);

        CS_n = 1'b0; AS_n = 1'b0; LDS_n = 1'b0; RW = 1'b0;
        REG_ADDR = 5'h0C; DATA_IN = 8'h5A;
        tick();
        RST_n = 1'b0;
        tick();
        chk("midrst_dtack", DTACK_n, 1'b1);
        chk("midrst_data_out", DATA_OUT, 8'h00);
        RST_n = 1'b1;
        bus_idle();
        tick();
        reg_rd(5'h0C, d);
        chk("midrst_reload", d, 8'h00);
        reg_rd(5'h00, d);
        chk("midrst_t0_ctrl", d, 8'h05);
        reg_rd(5'h09, d);
        chk("midrst_t1_pend", d, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
